// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux (rr_arb_mux).
// The lock-state type is only used when ARB_MUX_LOCK_EN is defined.
package rr_arb_mux_pkg;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_LOCKED
  } lock_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus its index, searching from the channel
// after the last accepted grant; the pointer moves only when a grant is accepted.
module rr_arbiter import rr_arb_mux_pkg::*; #(
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              accept,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  localparam logic [SEL_W:0] NUM_EXT = (SEL_W+1)'(NUM_IN);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    sum       = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      sum = {1'b0, last_grant} + (SEL_W+1)'(k);
      if (sum >= NUM_EXT) begin
        sum = sum - NUM_EXT;
      end
      cand = sum[SEL_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset value makes channel 0 the first candidate after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SEL_W'(NUM_IN - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 round-robin arbitrating mux with a single registered output stage.
// Define ARB_MUX_LOCK_EN to hold a grant for a whole packet (until in_last).
module rr_arb_mux import rr_arb_mux_pkg::*; #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 8,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel
);

  logic              load;
  logic              xfer;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  sel_data;

  assign load     = !out_valid || out_ready;
  assign in_ready = (load && rst_n) ? grant : '0;
  assign xfer     = |in_ready;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .accept    (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

`ifdef ARB_MUX_LOCK_EN
  lock_state_e      state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOCK_IDLE;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // While locked, every other channel is hidden from the arbiter.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    req       = in_valid;
    if (state_q == LOCK_LOCKED) begin
      req = in_valid & (NUM_IN'(1) << lock_ch_q);
    end
    if (xfer) begin
      case (state_q)
        LOCK_IDLE: begin
          if (!in_last[grant_idx]) begin
            state_d   = LOCK_LOCKED;
            lock_ch_d = grant_idx;
          end
        end
        LOCK_LOCKED: begin
          if (in_last[grant_idx]) begin
            state_d = LOCK_IDLE;
          end
        end
        default: state_d = LOCK_IDLE;
      endcase
    end
  end
`else
  logic unused_last;

  assign req         = in_valid;
  assign unused_last = ^in_last;
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Data and index are captured together; out_data keeps its value when the stage drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (NUM_IN=4, WIDTH=8); expectations follow
// ARB_MUX_LOCK_EN so the same file covers both builds.
module tb_rr_arb_mux;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [31:0] in_data;
  logic [3:0] in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] last;
    logic       oready;
    logic [3:0] exp_ready;
    logic       exp_ovalid;
    logic [7:0] exp_data;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vectors[$];
  vec_t expq[$];
  int   checks = 0;
  int   errors = 0;

  rr_arb_mux #(.NUM_IN(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last, input logic oready,
                              input logic [3:0] exp_ready, input logic exp_ovalid,
                              input logic [7:0] exp_data, input logic [1:0] exp_sel);
    vec_t v;
    v.valid      = valid;
    v.last       = last;
    v.oready     = oready;
    v.exp_ready  = exp_ready;
    v.exp_ovalid = exp_ovalid;
    v.exp_data   = exp_data;
    v.exp_sel    = exp_sel;
    return v;
  endfunction

  // Called just after a rising edge: drive inputs and queue what must come back.
  task automatic applyStimulus(input vec_t v);
    in_valid  = v.valid;
    in_last   = v.last;
    out_ready = v.oready;
    expq.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.queue: actual empty required entry", tag);
      return;
    end
    e = expq.pop_front();
    #4;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(e.exp_ready));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e.exp_ovalid));
    check({tag, ".out_data"}, 32'(out_data), 32'(e.exp_data));
    if (e.exp_ovalid) begin
      check({tag, ".out_sel"}, 32'(out_sel), 32'(e.exp_sel));
    end
  endtask

  task automatic runVectors(input string phase);
    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i]);
      checkOutput($sformatf("%s%0d", phase, i));
    end
    vectors.delete();
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    #1 rst_n = 1'b0;
    #2;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    check("reset.out_sel", 32'(out_sel), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming, stall/hold, drain and wrap-around grants.
    vectors.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0));
    vectors.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
    vectors.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3));
    vectors.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0));
    vectors.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0));
    vectors.push_back(mk(4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0100, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0110, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0100, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
    vectors.push_back(mk(4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0));
    vectors.push_back(mk(4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3));
    vectors.push_back(mk(4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0));
    vectors.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0));
    runVectors("A");

    // Asynchronous reset in mid-cycle while a beat is held.
    applyStimulus(mk(4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'h12, 2'd2));
    checkOutput("R0");
    #1;
    rst_n    = 1'b0;
    in_valid = 4'b1111;
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.out_sel", 32'(out_sel), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst.edge_out_valid", 32'(out_valid), 32'd0);
    check("rst.edge_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    applyStimulus(mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0));
    checkOutput("R1");
    applyStimulus(mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0));
    checkOutput("R2");

    // Channel 2 packet (last on third beat) competing with channel 1.
    vectors.push_back(mk(4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
`ifdef ARB_MUX_LOCK_EN
    vectors.push_back(mk(4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
`else
    vectors.push_back(mk(4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
    vectors.push_back(mk(4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2));
    vectors.push_back(mk(4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
    vectors.push_back(mk(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
`endif
    vectors.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1));
    runVectors("P");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of input channels, range 2..16.
REQ-002 SHALL have parameter WIDTH, default 8: data bits per channel, minimum 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  NUM_IN  per-channel request; bit i belongs to channel i.
REQ-006 SHALL have port in_ready  output  NUM_IN  per-channel accept; combinational.
REQ-007 SHALL have port in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  NUM_IN  per-channel end-of-packet flag; ignored unless ARB_MUX_LOCK_EN is defined.
REQ-009 SHALL have port out_valid  output  1  output register holds a beat.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_sel  output  SEL_W  index of the source channel of out_data; SEL_W = max(1, clog2(NUM_IN)).

Function
REQ-013 Channel i transfer SHALL occur when in_valid[i] and in_ready[i] are both high at a rising edge; the output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 load = !out_valid || out_ready; at most one in_ready bit SHALL be high, and only when load is high.
REQ-015 Grant SHALL be round-robin: search starts at channel (last_grant+1) mod NUM_IN and wraps; the first channel with in_valid high is granted.
REQ-016 On a transfer the output register SHALL capture the data and index in the same edge, giving 1-cycle latency from transfer to out_valid.
REQ-017 last_grant SHALL update only on an input transfer, never on a request that is not accepted.
REQ-018 With out_valid high and out_ready low, out_data and out_sel SHALL hold; no in_ready SHALL be high.
REQ-019 A simultaneous output transfer and new input transfer SHALL sustain one beat per cycle with no bubble.
REQ-020 When load is high and no in_valid bit is set, out_valid SHALL fall after the output transfer; out_data SHALL hold its last value.
REQ-021 in_valid changing while not granted SHALL have no effect on state.

Reset
REQ-022 rst_n low SHALL force out_valid=0, out_data=0, out_sel=0, last_grant=NUM_IN-1 (channel 0 first after reset), lock state IDLE, regardless of clk.
REQ-023 Reset assertion mid-packet or with a held beat SHALL discard the beat and any lock; in_ready SHALL be all-zero while rst_n is low.
REQ-024 Release SHALL take effect on the first rising edge with rst_n high; no transfer SHALL occur before that edge.

Configuration
REQ-025 Macro ARB_MUX_LOCK_EN defined: a two-state FSM (IDLE, LOCKED) SHALL exist; IDLE->LOCKED on a transfer with in_last[i]=0; LOCKED->IDLE on a transfer from the locked channel with in_last=1.
REQ-026 While LOCKED, only the locked channel SHALL be grantable, even when its in_valid is low and others request.
REQ-027 Macro undefined: no FSM SHALL be present; each beat is arbitrated independently; in_last SHALL be unused.

Structure
REQ-028 Package rr_arb_mux_pkg SHALL hold the SEL_W computation function and the lock-state enumerated type.
REQ-029 Sub-module rr_arbiter (NUM_IN requests in, one-hot grant out, pointer update on accept) SHALL contain the round-robin logic; rr_arb_mux SHALL instantiate it once.

Verification
REQ-030 Reset, then in_valid=4'b1111, out_ready=1, data i=8'h10+i -> out_data sequence 10,11,12,13,10 on consecutive cycles, out_sel 0,1,2,3,0.
REQ-031 in_valid=4'b0100, out_ready=0 for 3 cycles -> one beat 8'h12 captured, held for 3 cycles, in_ready=0 during stall; released on out_ready=1.
REQ-032 last_grant=1, in_valid=4'b0001 -> grant wraps to channel 0, out_sel=0.
REQ-033 rst_n pulsed low mid-clock with out_valid=1 -> out_valid=0 immediately; first grant after release goes to channel 0.
REQ-034 LOCK_EN: channel 2 sends 3 beats, in_last=0,0,1, channel 1 valid throughout, channel 2 valid low for 1 cycle mid-packet -> channel 1 receives no in_ready until channel 2's last beat, then granted next.
REQ-035 No LOCK_EN, same stimulus as REQ-034 -> beats interleave 2,1,2,1 per round-robin.
